// File: rtl/mac_pkg.sv
// Shared constants, beat tag type and saturation bound helpers for the MAC pipeline.
package mac_pkg;

  localparam int DEF_A_W     = 8;
  localparam int DEF_B_W     = 8;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_MUL_LAT = 2;
  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 4;
  localparam int ACC_W_MAX   = 48;

  typedef struct packed {
    logic valid;
    logic last;
  } beat_tag_t;

  // Largest/smallest value of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Signed A_W x B_W multiplier with MUL_LAT register stages; the beat tag travels alongside.
module mult_pipe
  import mac_pkg::*;
#(
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  beat_tag_t              tag_in,
  input  logic signed [A_W-1:0]  a,
  input  logic signed [B_W-1:0]  b,
  output beat_tag_t              tag_out,
  output logic signed [A_W+B_W-1:0] p
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;

  // Widen before multiplying so the product is full precision.
  assign a_ext = P_W'(a);
  assign b_ext = P_W'(b);

  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_stage
      logic signed [P_W-1:0] p_src;
      beat_tag_t             tag_src;
      logic signed [P_W-1:0] p_reg;
      beat_tag_t             tag_reg;

      if (gi == 0) begin : g_head
        assign p_src   = a_ext * b_ext;
        assign tag_src = tag_in;
      end else begin : g_body
        assign p_src   = g_stage[gi-1].p_reg;
        assign tag_src = g_stage[gi-1].tag_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_reg   <= '0;
          tag_reg <= '0;
        end else if (en) begin
          p_reg   <= p_src;
          tag_reg <= tag_src;
        end
      end
    end
  endgenerate

  assign p       = g_stage[MUL_LAT-1].p_reg;
  assign tag_out = g_stage[MUL_LAT-1].tag_reg;

endmodule

// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate producing one dot product per IN_LAST beat,
// with ready/valid flow control, saturating or wrapping accumulation and a sticky overflow flag.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int SAT_EN  = 1
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    IN_LAST,
  input  logic signed [A_W-1:0]   A,
  input  logic signed [B_W-1:0]   B,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic signed [ACC_W-1:0] OUT_ACC,
  output logic                    OUT_SAT
);

  localparam int P_W = A_W + B_W;
  localparam logic signed [63:0]      MAX_L   = sat_max(ACC_W);
  localparam logic signed [63:0]      MIN_L   = sat_min(ACC_W);
  localparam logic signed [ACC_W-1:0] ACC_MAX = MAX_L[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] ACC_MIN = MIN_L[ACC_W-1:0];

  logic                    stall;
  beat_tag_t               beat_tag;
  beat_tag_t               mul_tag;
  logic signed [P_W-1:0]   mul_p;

  beat_tag_t               prod_tag_reg;
  logic signed [ACC_W-1:0] prod_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic                    sticky_reg;
  logic                    out_valid_reg;
  logic signed [ACC_W-1:0] out_acc_reg;
  logic                    out_sat_reg;

  logic signed [ACC_W:0]   sum_wide;
  logic                    overflow;
  logic signed [ACC_W-1:0] acc_next;

  assign stall    = out_valid_reg & ~OUT_READY;
  assign IN_READY = ~stall;

  assign beat_tag.valid = IN_VALID;
  assign beat_tag.last  = IN_VALID & IN_LAST;

  mult_pipe #(
    .A_W     (A_W),
    .B_W     (B_W),
    .MUL_LAT (MUL_LAT)
  ) u_mult (
    .clk     (CLK),
    .rst_n   (RSTN),
    .en      (~stall),
    .tag_in  (beat_tag),
    .a       (A),
    .b       (B),
    .tag_out (mul_tag),
    .p       (mul_p)
  );

  // One guard bit exposes overflow of the ACC_W-bit sum.
  always_comb begin
    sum_wide = {acc_reg[ACC_W-1], acc_reg} + {prod_reg[ACC_W-1], prod_reg};
    overflow = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_next = sum_wide[ACC_W-1:0];
    if ((SAT_EN != 0) && overflow) begin
      acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prod_tag_reg  <= '0;
      prod_reg      <= '0;
      acc_reg       <= '0;
      sticky_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_acc_reg   <= '0;
      out_sat_reg   <= 1'b0;
    end else if (!stall) begin
      prod_tag_reg  <= mul_tag;
      prod_reg      <= ACC_W'(mul_p);
      out_valid_reg <= prod_tag_reg.valid & prod_tag_reg.last;
      if (prod_tag_reg.valid) begin
        if (prod_tag_reg.last) begin
          out_acc_reg <= acc_next;
          out_sat_reg <= sticky_reg | overflow;
          acc_reg     <= '0;
          sticky_reg  <= 1'b0;
        end else begin
          acc_reg     <= acc_next;
          sticky_reg  <= sticky_reg | overflow;
        end
      end
    end
  end

  assign OUT_VALID = out_valid_reg;
  assign OUT_ACC   = out_acc_reg;
  assign OUT_SAT   = out_sat_reg;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: default, 16-bit saturating and 16-bit wrapping instances share stimulus.
module tb_mac_pipe;

  logic clk = 1'b0;
  logic rstn;
  logic in_valid;
  logic in_last;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic out_ready;

  logic in_ready, in_ready_s, in_ready_w;
  logic out_valid, out_valid_s, out_valid_w;
  logic signed [23:0] out_acc;
  logic signed [15:0] out_acc_s, out_acc_w;
  logic out_sat, out_sat_s, out_sat_w;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic signed [23:0] acc;
    logic               sat;
    logic signed [15:0] acc_s;
    logic               sat_s;
    logic signed [15:0] acc_w;
    logic               sat_w;
  } res_t;

  res_t res_q[$];

  always #5 clk = ~clk;

  mac_pipe #(.A_W(8), .B_W(8), .ACC_W(24), .MUL_LAT(2), .SAT_EN(1)) dut (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_LAST(in_last),
    .A(a), .B(b), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_ACC(out_acc), .OUT_SAT(out_sat)
  );

  mac_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .MUL_LAT(2), .SAT_EN(1)) u_sat16 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready_s), .IN_LAST(in_last),
    .A(a), .B(b), .OUT_VALID(out_valid_s), .OUT_READY(out_ready), .OUT_ACC(out_acc_s), .OUT_SAT(out_sat_s)
  );

  mac_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .MUL_LAT(2), .SAT_EN(0)) u_wrap16 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready_w), .IN_LAST(in_last),
    .A(a), .B(b), .OUT_VALID(out_valid_w), .OUT_READY(out_ready), .OUT_ACC(out_acc_w), .OUT_SAT(out_sat_w)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Holds the beat on the bus until it is accepted; leaves IN_VALID high for back-to-back beats.
  task automatic send_beat(input int av, input int bv, input bit lst);
    bit ok;
    int n;
    a        = 8'(av);
    b        = 8'(bv);
    in_last  = lst;
    in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      ok = in_ready;
      tick();
      n++;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain;
    repeat (10) tick();
  endtask

  task automatic pop_res(input string tag, output res_t r);
    check({tag, "_avail"}, (res_q.size() > 0) ? 1 : 0, 1);
    if (res_q.size() > 0) r = res_q.pop_front();
    else r = '0;
  endtask

  task automatic expect_res(input string tag, input int acc, input int sat);
    res_t r;
    pop_res(tag, r);
    check({tag, "_acc"}, r.acc, acc);
    check({tag, "_sat"}, r.sat, sat);
  endtask

  // One line per consumed result.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      res_q.push_back('{acc: out_acc, sat: out_sat, acc_s: out_acc_s, sat_s: out_sat_s,
                        acc_w: out_acc_w, sat_w: out_sat_w});
      $display("result acc=%0d sat=%0d acc16s=%0d sat16s=%0d acc16w=%0d sat16w=%0d",
               out_acc, out_sat, out_acc_s, out_sat_s, out_acc_w, out_sat_w);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int n;
    int wn;

    rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    rstn = 1'b1;
    out_ready = 1'b1;
    tick();

    // Single beat and latency from accept to OUT_VALID.
    send_beat(-30, 40, 1);
    idle();
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("single_latency", n, 3);
    check("single_out_acc", out_acc, -1200);
    check("single_out_sat", out_sat, 0);
    drain();
    expect_res("single", -1200, 0);

    // Three-beat dot product immediately followed by a one-beat product.
    send_beat(-30, 40, 0);
    send_beat(-20, 40, 0);
    send_beat(-10, 40, 1);
    send_beat(5, 5, 1);
    idle();
    drain();
    expect_res("dot3", -2400, 0);
    expect_res("b2b", 25, 0);

    // 3 x 127*127 = 48387: fits 24 bits, clamps or wraps at 16 bits.
    send_beat(127, 127, 0);
    send_beat(127, 127, 0);
    send_beat(127, 127, 1);
    idle();
    drain();
    pop_res("big", r);
    check("big24_acc", r.acc, 48387);
    check("big24_sat", r.sat, 0);
    check("sat16_acc", r.acc_s, 32767);
    check("sat16_sat", r.sat_s, 1);
    check("wrap16_acc", r.acc_w, -17149);
    check("wrap16_sat", r.sat_w, 1);

    // Operand extremes.
    send_beat(-128, -128, 1);
    send_beat(-128, 127, 1);
    idle();
    drain();
    expect_res("ext_pos", 16384, 0);
    expect_res("ext_neg", -16256, 0);

    // Downstream stall with beats pending.
    out_ready = 1'b0;
    fork
      begin
        send_beat(2, 3, 1);
        send_beat(4, 5, 0);
        send_beat(6, 7, 1);
        send_beat(1, 1, 1);
        idle();
      end
      begin
        wn = 0;
        while (!out_valid && wn < 50) begin
          tick();
          wn++;
        end
        check("stall_wait", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
          check("stall_in_ready", in_ready, 0);
          check("stall_acc", out_acc, 6);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    expect_res("stall_r0", 6, 0);
    expect_res("stall_r1", 62, 0);
    expect_res("stall_r2", 1, 0);

    // Reset after two of three beats discards the partial sum.
    send_beat(1, 2, 0);
    send_beat(3, 4, 0);
    idle();
    rstn = 1'b0;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_acc", out_acc, 0);
    check("midrst_out_sat", out_sat, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();
    rstn = 1'b1;
    tick();
    send_beat(3, 4, 1);
    idle();
    drain();
    expect_res("post_rst", 12, 0);
    check("queue_empty", res_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
